bsg_dff_gatestack_sched: RTL and testbench

//  Write scheduler for a bsg_dff_gatestack bank (per-bit flops clocked by per-bit gate lines).
//  - Arbitrates round-robin among num_req_p requesters, each issuing a masked write.
//  - Sequences each write as data setup, then a single-cycle gate pulse, then data hold.
//  - Drives gatestack i0 (data) and i1 (gate) only from flops, so gate lines never glitch.

---
 rtl/bsg_dff_gatestack_sched_pkg.sv | 28 ++
 rtl/bsg_dff_gatestack_sched_rr.sv | 56 +++++
 rtl/bsg_dff_gatestack_sched.sv | 127 ++++++++++++
 tb/tb_bsg_dff_gatestack_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_dff_gatestack_sched_pkg.sv
// Shared types for the bsg_dff_gatestack write scheduler.
// The state encoding, per-write record and id-width helper live here so that
// the arbiter and the top level agree on them.
package bsg_dff_gatestack_sched_pkg;

  // Default gatestack width; the per-write record is sized to it.
  localparam int unsigned gs_width_lp = 16;

  // Write sequence: data setup, one gate pulse, data hold.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // One accepted write: data to present on i0, mask of gate lines to pulse.
  typedef struct packed {
    logic [gs_width_lp-1:0] data;
    logic [gs_width_lp-1:0] mask;
  } write_s;

  // Width of a requester id; a lone requester still gets a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_dff_gatestack_sched_rr.sv
// Rotating-priority arbiter for the gatestack write scheduler.
// Grants the first set request at or after the pointer, wrapping around.
// The pointer moves to (grant + 1) mod num_req_p whenever yumi_i is high.
module bsg_dff_gatestack_sched_rr
  import bsg_dff_gatestack_sched_pkg::*;
#(
  parameter  int unsigned num_req_p = 2,
  localparam int unsigned id_w_lp   = id_width(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] v_i,
  input  logic                 yumi_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [id_w_lp-1:0]   id_o
);

  logic [id_w_lp-1:0] ptr_r;
  logic               found;

  // Pick the first valid requester at or above the pointer, else the lowest one.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && v_i[i] && (i >= int'(ptr_r))) begin
        grant_o[i] = 1'b1;
        id_o       = id_w_lp'(i);
        found      = 1'b1;
      end
    end
    // Nothing at or above the pointer: any remaining hit is below it.
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && v_i[i]) begin
        grant_o[i] = 1'b1;
        id_o       = id_w_lp'(i);
        found      = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner when its request is taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!reset_n_i) begin
      ptr_r <= '0;
    end else if (yumi_i) begin
      ptr_r <= (id_o == id_w_lp'(num_req_p - 1)) ? '0 : id_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_dff_gatestack_sched.sv
// Write scheduler for a bsg_dff_gatestack bank.
// Accepts one masked write at a time from num_req_p requesters (round robin)
// and plays it out as SETUP (data), PULSE (gate = mask), HOLD (data kept).
// gate_data_o and gate_clk_o come straight from flops so the gate lines
// never glitch.
// Optional feature: define BSG_DFF_GATESTACK_SCHED_SHADOW_EN to add shadow_o,
// a register copy of the gatestack contents.
module bsg_dff_gatestack_sched
  import bsg_dff_gatestack_sched_pkg::*;
#(
  parameter  int unsigned width_p   = gs_width_lp,
  parameter  int unsigned num_req_p = 2,
  localparam int unsigned id_w_lp   = id_width(num_req_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               v_i,
  input  logic [num_req_p-1:0][width_p-1:0]  data_i,
  input  logic [num_req_p-1:0][width_p-1:0]  mask_i,
  output logic [num_req_p-1:0]               ready_o,
  output logic [width_p-1:0]                 gate_data_o,
  output logic [width_p-1:0]                 gate_clk_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [id_w_lp-1:0]                 grant_id_o
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
  ,
  output logic [width_p-1:0]                 shadow_o
`endif
);

  state_e                 state_r, state_n;
  logic                   idle;
  logic                   accept;
  logic [num_req_p-1:0]   arb_grant;
  logic [id_w_lp-1:0]     arb_id;
  write_s                 sel;
  write_s                 wr_r;

  assign idle   = (state_r == IDLE);
  assign accept = idle && (|v_i);
  assign busy_o = !idle;

  bsg_dff_gatestack_sched_rr #(
    .num_req_p (num_req_p)
  ) rr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .yumi_i    (accept),
    .grant_o   (arb_grant),
    .id_o      (arb_id)
  );

  // Offer the arbiter's grant only while idle and out of reset.
  assign ready_o = (idle && reset_n_i) ? arb_grant : '0;

  // Mux the granted requester's data and mask (one-hot AND-OR).
  always_comb begin
    sel = '0;
    for (int r = 0; r < num_req_p; r++) begin
      if (arb_grant[r]) begin
        sel.data = sel.data | gs_width_lp'(data_i[r]);
        sel.mask = sel.mask | gs_width_lp'(mask_i[r]);
      end
    end
  end

  // Sequence state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state: each non-idle state lasts exactly one cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   state_n = PULSE;
      PULSE:   state_n = HOLD;
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write latch; its data field is the gatestack data bus itself, so the
  // bus changes only on the accepting edge and holds through IDLE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_r       <= '0;
      grant_id_o <= '0;
    end else if (accept) begin
      wr_r       <= sel;
      grant_id_o <= arb_id;
    end
  end

  assign gate_data_o = wr_r.data[width_p-1:0];

  // Gate pulse in the PULSE cycle and done flag in the HOLD cycle, both registered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gate_clk_o <= '0;
      done_o     <= 1'b0;
    end else begin
      gate_clk_o <= (state_r == SETUP) ? wr_r.mask[width_p-1:0] : '0;
      done_o     <= (state_r == PULSE);
    end
  end

`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
  // Mirror the bits the gate pulse just captured into the gatestack.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shadow_o <= '0;
    end else if (state_r == PULSE) begin
      shadow_o <= (shadow_o & ~wr_r.mask[width_p-1:0])
                | (gate_data_o & wr_r.mask[width_p-1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_dff_gatestack_sched.sv
// Directed bench for bsg_dff_gatestack_sched (width 16, two requesters).
// Covers reset state, single write, zero mask, contention, reset during
// PULSE and back-to-back writes; shadow_o when the shadow macro is defined.
module tb_bsg_dff_gatestack_sched;

  localparam int W = 16;
  localparam int N = 2;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [N-1:0]      v_i;
  logic [N-1:0][W-1:0] data_i;
  logic [N-1:0][W-1:0] mask_i;
  logic [N-1:0]      ready_o;
  logic [W-1:0]      gate_data_o;
  logic [W-1:0]      gate_clk_o;
  logic              busy_o;
  logic              done_o;
  logic [0:0]        grant_id_o;
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
  logic [W-1:0]      shadow_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_dff_gatestack_sched #(
    .width_p   (W),
    .num_req_p (N)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .mask_i      (mask_i),
    .ready_o     (ready_o),
    .gate_data_o (gate_data_o),
    .gate_clk_o  (gate_clk_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .grant_id_o  (grant_id_o)
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
    ,
    .shadow_o    (shadow_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int exp_id;

    // Reset state; ready_o must stay low even with requests present.
    reset_n_i = 1'b0;
    v_i       = '1;
    data_i    = '0;
    mask_i    = '0;
    #2;
    check("rst_ready", ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_gclk", gate_clk_o, 0);
    check("rst_gdata", gate_data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_id", grant_id_o, 0);
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
    check("rst_shadow", shadow_o, 0);
`endif
    cyc();
    v_i       = '0;
    reset_n_i = 1'b1;
    #1;

    // Single write from r0.
    v_i       = 2'b01;
    data_i[0] = 16'hA5A5;
    mask_i[0] = 16'h00FF;
    #1;
    check("s1_ready_t0", ready_o, 2'b01);
    cyc();
    v_i = '0;
    check("s1_busy_t1", busy_o, 1);
    check("s1_gdata_t1", gate_data_o, 16'hA5A5);
    check("s1_gclk_t1", gate_clk_o, 0);
    check("s1_id_t1", grant_id_o, 0);
    check("s1_done_t1", done_o, 0);
    cyc();
    check("s1_gclk_t2", gate_clk_o, 16'h00FF);
    check("s1_gdata_t2", gate_data_o, 16'hA5A5);
    check("s1_done_t2", done_o, 0);
    cyc();
    check("s1_gclk_t3", gate_clk_o, 0);
    check("s1_done_t3", done_o, 1);
    check("s1_busy_t3", busy_o, 1);
    cyc();
    check("s1_done_t4", done_o, 0);
    check("s1_busy_t4", busy_o, 0);
    check("s1_gdata_t4", gate_data_o, 16'hA5A5);
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
    check("s1_shadow", shadow_o, 16'h00A5);
`endif

    // Zero mask from r1 (pointer now 1).
    v_i       = 2'b10;
    data_i[1] = 16'hFFFF;
    mask_i[1] = 16'h0000;
    #1;
    check("s3_ready_t0", ready_o, 2'b10);
    cyc();
    v_i = '0;
    check("s3_busy_t1", busy_o, 1);
    check("s3_gclk_t1", gate_clk_o, 0);
    check("s3_gdata_t1", gate_data_o, 16'hFFFF);
    check("s3_id_t1", grant_id_o, 1);
    cyc();
    check("s3_gclk_t2", gate_clk_o, 0);
    check("s3_busy_t2", busy_o, 1);
    check("s3_done_t2", done_o, 0);
    cyc();
    check("s3_gclk_t3", gate_clk_o, 0);
    check("s3_done_t3", done_o, 1);
    check("s3_busy_t3", busy_o, 1);
    cyc();
    check("s3_busy_t4", busy_o, 0);
    check("s3_done_t4", done_o, 0);

    // Contention from reset: both requesters held valid.
    reset_n_i = 1'b0;
    #1;
    reset_n_i = 1'b1;
    v_i       = 2'b11;
    data_i[0] = 16'h1111;
    data_i[1] = 16'h2222;
    mask_i[0] = 16'hFFFF;
    mask_i[1] = 16'hFFFF;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      check("s2_ready_idle", ready_o, (exp_id == 1) ? 2'b10 : 2'b01);
      cyc();
      check("s2_id", grant_id_o, exp_id);
      check("s2_gdata", gate_data_o, (exp_id == 1) ? 16'h2222 : 16'h1111);
      check("s2_ready_busy", ready_o, 0);
      cyc();
      cyc();
      cyc();
    end
    v_i = '0;
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
    check("s2_shadow", shadow_o, 16'h2222);
`endif

    // Reset during PULSE (pointer back at 0 after the r0,r1,r0,r1 run).
    v_i       = 2'b01;
    data_i[0] = 16'h5A5A;
    mask_i[0] = 16'hF0F0;
    #1;
    check("s4_ready_t0", ready_o, 2'b01);
    cyc();
    v_i = '0;
    cyc();
    check("s4_gclk_t2", gate_clk_o, 16'hF0F0);
    #3;
    reset_n_i = 1'b0;
    v_i       = 2'b11;
    #1;
    check("s4_gclk_rst", gate_clk_o, 0);
    check("s4_busy_rst", busy_o, 0);
    check("s4_ready_rst", ready_o, 0);
    check("s4_gdata_rst", gate_data_o, 0);
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
    check("s4_shadow_rst", shadow_o, 0);
`endif
    #1;
    reset_n_i = 1'b1;
    #1;
    check("s4_ready_ptr0", ready_o, 2'b01);
    v_i = 2'b10;
    #1;
    check("s4_ready_r1", ready_o, 2'b10);
    v_i = '0;

    // Back-to-back writes from r0.
    cyc();
    v_i       = 2'b01;
    data_i[0] = 16'h1234;
    mask_i[0] = 16'hFFFF;
    #1;
    check("s5_ready_a", ready_o, 2'b01);
    cyc();
    check("s5_gdata_setup_a", gate_data_o, 16'h1234);
    check("s5_ready_setup", ready_o, 0);
    data_i[0] = 16'h0000;
    mask_i[0] = 16'h000F;
    cyc();
    check("s5_gclk_a", gate_clk_o, 16'hFFFF);
    check("s5_gdata_pulse_a", gate_data_o, 16'h1234);
    cyc();
    check("s5_done_a", done_o, 1);
    check("s5_gdata_hold_a", gate_data_o, 16'h1234);
    cyc();
    check("s5_ready_b", ready_o, 2'b01);
    check("s5_done_idle", done_o, 0);
    cyc();
    v_i = '0;
    check("s5_busy_setup_b", busy_o, 1);
    check("s5_gdata_setup_b", gate_data_o, 16'h0000);
    cyc();
    check("s5_gclk_b", gate_clk_o, 16'h000F);
    check("s5_gdata_pulse_b", gate_data_o, 16'h0000);
    cyc();
    check("s5_done_b", done_o, 1);
    cyc();
    check("s5_busy_end", busy_o, 0);
`ifdef BSG_DFF_GATESTACK_SCHED_SHADOW_EN
    check("s5_shadow", shadow_o, 16'h1230);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
